// File: rtl/pkt_buf_ctrl_if.sv
// Ingress, egress and buffer-memory signal bundle for pkt_buf_ctrl.
// master is the controller's view; slave is the surrounding environment's view.
interface pkt_buf_ctrl_if #(
    parameter int DATA_WIDTH = 64,
    parameter int CTRL_WIDTH = DATA_WIDTH / 8,
    parameter int ADDR_WIDTH = 8
);
    logic [DATA_WIDTH-1:0]            in_data;
    logic [CTRL_WIDTH-1:0]            in_ctrl;
    logic                             in_wr;
    logic                             in_rdy;
    logic [DATA_WIDTH-1:0]            out_data;
    logic [CTRL_WIDTH-1:0]            out_ctrl;
    logic                             out_wr;
    logic                             out_rdy;
    logic [ADDR_WIDTH-1:0]            mem_addr;
    logic [DATA_WIDTH+CTRL_WIDTH-1:0] mem_wdata;
    logic                             mem_we;
    logic [DATA_WIDTH+CTRL_WIDTH-1:0] mem_rdata;

    modport master (
        input  in_data, in_ctrl, in_wr,
        output in_rdy,
        output out_data, out_ctrl, out_wr,
        input  out_rdy,
        output mem_addr, mem_wdata, mem_we,
        input  mem_rdata
    );

    modport slave (
        output in_data, in_ctrl, in_wr,
        input  in_rdy,
        input  out_data, out_ctrl, out_wr,
        output out_rdy,
        input  mem_addr, mem_wdata, mem_we,
        output mem_rdata
    );
endinterface

// File: rtl/pkt_buf_ctrl.sv
// Packet buffer controller: store one packet, hand the buffer to a CPU, then stream it out.
// Optional PROC watchdog enabled by defining PKT_BUF_CTRL_WATCHDOG_EN.
module pkt_buf_ctrl #(
    parameter int DATA_WIDTH = 64,
    parameter int CTRL_WIDTH = DATA_WIDTH / 8,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                             clk,
    input  logic                             reset,
    pkt_buf_ctrl_if.master                   bus,
    output logic                             cpu_start,
    input  logic                             cpu_done,
    input  logic [ADDR_WIDTH-1:0]            cpu_addr,
    input  logic [DATA_WIDTH+CTRL_WIDTH-1:0] cpu_wdata,
    input  logic                             cpu_we,
    output logic [ADDR_WIDTH:0]              pkt_len,
    output logic [15:0]                      pkt_cnt,
    output logic                             busy,
    output logic                             timeout_flag
);
    localparam logic [ADDR_WIDTH:0] DEPTH = {1'b1, {ADDR_WIDTH{1'b0}}};

    typedef enum logic [1:0] {IDLE, RECV, PROC, SEND} state_t;

    state_t              state_q, state_d;
    logic [ADDR_WIDTH:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH:0] pkt_len_q, pkt_len_d;
    logic [15:0]         pkt_cnt_q, pkt_cnt_d;
    logic                prev_zero_q, prev_zero_d;
    logic                cpu_start_q, cpu_start_d;
    logic                rd_pend_q, rd_pend_d;
    logic                mem_we_c;
    logic                ctrl_nz;
    logic                wr_room;
    logic                wd_expired;

`ifdef PKT_BUF_CTRL_WATCHDOG_EN
    logic [9:0] wd_cnt_q;
    logic       timeout_q;

    always_ff @(posedge clk) begin
        if (reset || state_q != PROC) begin
            wd_cnt_q <= '0;
        end else begin
            wd_cnt_q <= wd_cnt_q + 10'd1;
        end
        if (reset) begin
            timeout_q <= 1'b0;
        end else if (wd_expired && !cpu_done) begin
            timeout_q <= 1'b1;
        end
    end

    assign wd_expired   = (state_q == PROC) && (wd_cnt_q == '1);
    assign timeout_flag = timeout_q;
`else
    assign wd_expired   = 1'b0;
    assign timeout_flag = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            pkt_len_q   <= '0;
            pkt_cnt_q   <= '0;
            prev_zero_q <= 1'b0;
            cpu_start_q <= 1'b0;
            rd_pend_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            pkt_len_q   <= pkt_len_d;
            pkt_cnt_q   <= pkt_cnt_d;
            prev_zero_q <= prev_zero_d;
            cpu_start_q <= cpu_start_d;
            rd_pend_q   <= rd_pend_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        pkt_len_d     = pkt_len_q;
        pkt_cnt_d     = pkt_cnt_q;
        prev_zero_d   = prev_zero_q;
        cpu_start_d   = 1'b0;
        rd_pend_d     = 1'b0;
        mem_we_c      = 1'b0;
        bus.in_rdy    = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_wdata = {bus.in_ctrl, bus.in_data};
        ctrl_nz       = |bus.in_ctrl;
        wr_room       = wr_ptr_q < DEPTH;
        unique case (state_q)
            IDLE: begin
                bus.in_rdy = 1'b1;
                if (bus.in_wr) begin
                    mem_we_c    = 1'b1;
                    wr_ptr_d    = {{ADDR_WIDTH{1'b0}}, 1'b1};
                    prev_zero_d = !ctrl_nz;
                    state_d     = RECV;
                end
            end
            RECV: begin
                bus.in_rdy   = 1'b1;
                bus.mem_addr = wr_ptr_q[ADDR_WIDTH-1:0];
                if (bus.in_wr) begin
                    // Pointer saturates at DEPTH, so it doubles as the stored word count.
                    mem_we_c    = wr_room;
                    wr_ptr_d    = wr_room ? wr_ptr_q + 1'b1 : wr_ptr_q;
                    prev_zero_d = !ctrl_nz;
                    if (ctrl_nz && prev_zero_q) begin
                        pkt_len_d   = wr_ptr_d;
                        cpu_start_d = 1'b1;
                        state_d     = PROC;
                    end
                end
            end
            PROC: begin
                bus.mem_addr  = cpu_addr;
                bus.mem_wdata = cpu_wdata;
                mem_we_c      = cpu_we;
                if (cpu_done || wd_expired) begin
                    rd_ptr_d = '0;
                    state_d  = SEND;
                end
            end
            SEND: begin
                bus.mem_addr = rd_ptr_q[ADDR_WIDTH-1:0];
                if (bus.out_rdy && rd_ptr_q < pkt_len_q) begin
                    rd_ptr_d  = rd_ptr_q + 1'b1;
                    rd_pend_d = 1'b1;
                end
                if (rd_pend_q && rd_ptr_q == pkt_len_q) begin
                    pkt_cnt_d = pkt_cnt_q + 16'd1;
                    state_d   = IDLE;
                end
            end
        endcase
    end

    assign bus.mem_we   = mem_we_c && !reset;
    assign bus.out_wr   = rd_pend_q;
    assign bus.out_data = rd_pend_q ? bus.mem_rdata[DATA_WIDTH-1:0] : '0;
    assign bus.out_ctrl = rd_pend_q ? bus.mem_rdata[DATA_WIDTH+CTRL_WIDTH-1:DATA_WIDTH] : '0;
    assign cpu_start    = cpu_start_q;
    assign pkt_len      = pkt_len_q;
    assign pkt_cnt      = pkt_cnt_q;
    assign busy         = state_q != IDLE;
endmodule

// File: tb/tb_pkt_buf_ctrl.sv
// Randomized scoreboard bench for pkt_buf_ctrl with a word-queue reference model.
module tb_pkt_buf_ctrl;
    localparam int DW    = 64;
    localparam int CW    = 8;
    localparam int AW    = 4;
    localparam int MW    = DW + CW;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          reset;
    logic          cpu_start, cpu_done, cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [MW-1:0] cpu_wdata;
    logic [AW:0]   pkt_len;
    logic [15:0]   pkt_cnt;
    logic          busy, timeout_flag;

    always #5 clk = ~clk;

    pkt_buf_ctrl_if #(.DATA_WIDTH(DW), .CTRL_WIDTH(CW), .ADDR_WIDTH(AW)) bus ();

    pkt_buf_ctrl #(.DATA_WIDTH(DW), .CTRL_WIDTH(CW), .ADDR_WIDTH(AW)) dut (
        .clk          (clk),
        .reset        (reset),
        .bus          (bus),
        .cpu_start    (cpu_start),
        .cpu_done     (cpu_done),
        .cpu_addr     (cpu_addr),
        .cpu_wdata    (cpu_wdata),
        .cpu_we       (cpu_we),
        .pkt_len      (pkt_len),
        .pkt_cnt      (pkt_cnt),
        .busy         (busy),
        .timeout_flag (timeout_flag)
    );

    // External buffer RAM: synchronous write, read data one cycle after address.
    logic [MW-1:0] ram [DEPTH];
    always @(posedge clk) begin
        if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
        bus.mem_rdata <= ram[bus.mem_addr];
    end

    int            total = 0;
    int            bad   = 0;
    logic [MW-1:0] sb [$];
    logic [MW-1:0] ref_mem [DEPTH];
    logic [MW-1:0] pkt_q [$];
    int            cpu_a_q [$];
    logic [MW-1:0] cpu_d_q [$];
    int            exp_cnt = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        logic [MW-1:0] e;
        if (!reset && bus.out_wr) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL egress_unexpected: got word %0h expected no word", {bus.out_ctrl, bus.out_data});
            end else begin
                e = sb.pop_front();
                check("egress_word", {bus.out_ctrl, bus.out_data}, e);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [MW-1:0] mk_word(input logic [CW-1:0] c);
        return {c, 32'($urandom), 32'($urandom)};
    endfunction

    // Random ctrl lanes until the end-of-packet rule (nonzero after zero) is met.
    task automatic gen_packet();
        bit            prev_zero = 1'b0;
        bit            fin = 1'b0;
        logic [CW-1:0] c;
        pkt_q.delete();
        while (!fin) begin
            c = ($urandom_range(0, 1) == 0) ? '0 : CW'($urandom_range(1, 255));
            if (pkt_q.size() >= 28) c = prev_zero ? CW'(8'h01) : '0;
            pkt_q.push_back(mk_word(c));
            if (c != 0 && prev_zero) fin = 1'b1;
            prev_zero = (c == 0);
        end
    endtask

    task automatic run_packet(input int done_delay, input int rdy_mode);
        int  exp_len;
        int  n_proc;
        bit  fin = 1'b0;
        bit  tog = 1'b1;
        foreach (pkt_q[i]) begin
            while ($urandom_range(0, 3) == 0) begin
                bus.in_wr = 1'b0;
                tick();
            end
            bus.in_wr = 1'b1;
            {bus.in_ctrl, bus.in_data} = pkt_q[i];
            check("in_rdy_recv", bus.in_rdy, 1'b1);
            tick();
        end
        bus.in_wr = 1'b0;
        exp_len = (pkt_q.size() < DEPTH) ? pkt_q.size() : DEPTH;
        for (int i = 0; i < exp_len; i++) ref_mem[i] = pkt_q[i];
        check("cpu_start_pulse", cpu_start, 1'b1);
        check("busy_proc", busy, 1'b1);
        check("in_rdy_proc", bus.in_rdy, 1'b0);
        check("pkt_len", pkt_len, exp_len);

`ifdef PKT_BUF_CTRL_WATCHDOG_EN
        n_proc = (done_delay >= 0) ? done_delay + 1 : 1024;
`else
        n_proc = (done_delay >= 0) ? done_delay + 1 : 2000;
`endif
        for (int c = 0; c < n_proc; c++) begin
            if (c == 1) check("cpu_start_single", cpu_start, 1'b0);
            if (c < cpu_a_q.size()) begin
                cpu_we    = 1'b1;
                cpu_addr  = AW'(cpu_a_q[c]);
                cpu_wdata = cpu_d_q[c];
                ref_mem[cpu_a_q[c]] = cpu_d_q[c];
            end else begin
                cpu_we = 1'b0;
            end
            cpu_done = (c == done_delay);
            tick();
        end
        cpu_we   = 1'b0;
        cpu_done = 1'b0;
        if (done_delay < 0) begin
`ifdef PKT_BUF_CTRL_WATCHDOG_EN
            check("wd_timeout_flag", timeout_flag, 1'b1);
            check("wd_busy_send", busy, 1'b1);
`else
            check("nowd_still_busy", busy, 1'b1);
            check("nowd_in_rdy", bus.in_rdy, 1'b0);
            check("nowd_timeout_flag", timeout_flag, 1'b0);
            cpu_done = 1'b1;
            tick();
            cpu_done = 1'b0;
`endif
        end
        for (int i = 0; i < exp_len; i++) sb.push_back(ref_mem[i]);

        for (int c = 0; c < 400 && !fin; c++) begin
            case (rdy_mode)
                0:       bus.out_rdy = 1'b1;
                1:       begin bus.out_rdy = tog; tog = !tog; end
                default: bus.out_rdy = 1'($urandom_range(0, 1));
            endcase
            tick();
            if (!busy) fin = 1'b1;
        end
        bus.out_rdy = 1'b1;
        check("send_complete", fin, 1'b1);
        exp_cnt = (exp_cnt + 1) % 65536;
        check("pkt_cnt", pkt_cnt, exp_cnt);
        check("sb_drained", sb.size(), 0);
        check("in_rdy_after_send", bus.in_rdy, 1'b1);
        cpu_a_q.delete();
        cpu_d_q.delete();
    endtask

    initial begin
        #2ms;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "global timeout");
    end

    initial begin
        int n;
        int dd;
        reset = 1'b1;
        bus.in_wr = 1'b0; bus.in_data = '0; bus.in_ctrl = '0; bus.out_rdy = 1'b1;
        cpu_done = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        for (int i = 0; i < DEPTH; i++) ram[i] = '0;
        repeat (3) tick();
        reset = 1'b0;
        tick();
        check("rst_out_wr", bus.out_wr, 1'b0);
        check("rst_out_data", bus.out_data, 0);
        check("rst_out_ctrl", bus.out_ctrl, 0);
        check("rst_mem_we", bus.mem_we, 1'b0);
        check("rst_mem_addr", bus.mem_addr, 0);
        check("rst_cpu_start", cpu_start, 1'b0);
        check("rst_pkt_len", pkt_len, 0);
        check("rst_pkt_cnt", pkt_cnt, 0);
        check("rst_timeout", timeout_flag, 1'b0);
        check("rst_in_rdy", bus.in_rdy, 1'b1);
        check("rst_busy", busy, 1'b0);

        // Four-word packet, ctrl FF,00,00,01, cpu_done five cycles after cpu_start.
        pkt_q.delete();
        pkt_q.push_back(mk_word(8'hFF));
        pkt_q.push_back(mk_word(8'h00));
        pkt_q.push_back(mk_word(8'h00));
        pkt_q.push_back(mk_word(8'h01));
        run_packet(5, 0);

        // CPU rewrites word 2 while in PROC.
        pkt_q.delete();
        pkt_q.push_back(mk_word(8'h80));
        for (int i = 0; i < 4; i++) pkt_q.push_back(mk_word(8'h00));
        pkt_q.push_back(mk_word(8'h02));
        cpu_a_q.push_back(2);
        cpu_d_q.push_back(MW'(64'hDEADBEEF));
        run_packet(4, 1);

        // cpu_we outside PROC must not reach the buffer.
        cpu_we = 1'b1; cpu_addr = AW'(3); cpu_wdata = '1;
        check("idle_cpu_we_blocked", bus.mem_we, 1'b0);
        tick();
        cpu_we = 1'b0;

        // Oversize packet: 20 words into a 16-word buffer.
        pkt_q.delete();
        pkt_q.push_back(mk_word(8'h01));
        for (int i = 0; i < 18; i++) pkt_q.push_back(mk_word(8'h00));
        pkt_q.push_back(mk_word(8'h01));
        run_packet(2, 0);

        for (int p = 0; p < 20; p++) begin
            gen_packet();
            n = $urandom_range(0, 3);
            for (int k = 0; k < n; k++) begin
                cpu_a_q.push_back($urandom_range(0, DEPTH - 1));
                cpu_d_q.push_back(mk_word(CW'($urandom)));
            end
            dd = n + $urandom_range(0, 6);
            run_packet(dd, p % 3);
        end

        // Reset while word 2 of a packet is arriving.
        bus.in_wr = 1'b1; {bus.in_ctrl, bus.in_data} = mk_word(8'h10); tick();
        {bus.in_ctrl, bus.in_data} = mk_word(8'h00); tick();
        {bus.in_ctrl, bus.in_data} = mk_word(8'h00);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        bus.in_wr = 1'b0;
        exp_cnt = 0;
        check("midrst_in_rdy", bus.in_rdy, 1'b1);
        check("midrst_busy", busy, 1'b0);
        check("midrst_pkt_cnt", pkt_cnt, 0);
        check("midrst_pkt_len", pkt_len, 0);
        gen_packet();
        run_packet(3, 2);

        // CPU never signals done.
        gen_packet();
        run_packet(-1, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
